// File: rtl/bp_me_cache_dma_arbiter.sv
// Shares one memory DMA channel among several bsg_cache DMA ports: round-robin
// packet arbitration, with read fills and write-evict beats steered in grant order.
module bp_me_cache_dma_arbiter #(
  parameter int num_caches_p      = 2,
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 64,
  parameter int beats_per_block_p = 8,
  parameter int track_els_p       = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_caches_p*(addr_width_p+1)-1:0] dma_pkt_i,
  input  logic [num_caches_p-1:0]                  dma_pkt_v_i,
  output logic [num_caches_p-1:0]                  dma_pkt_yumi_o,
  output logic [num_caches_p*data_width_p-1:0]     dma_data_o,
  output logic [num_caches_p-1:0]                  dma_data_v_o,
  input  logic [num_caches_p-1:0]                  dma_data_ready_and_i,
  input  logic [num_caches_p*data_width_p-1:0]     dma_data_i,
  input  logic [num_caches_p-1:0]                  dma_data_v_i,
  output logic [num_caches_p-1:0]                  dma_data_yumi_o,
  output logic [addr_width_p:0]                    mem_pkt_o,
  output logic                                     mem_pkt_v_o,
  input  logic                                     mem_pkt_yumi_i,
  input  logic [data_width_p-1:0]                  mem_data_i,
  input  logic                                     mem_data_v_i,
  output logic                                     mem_data_ready_and_o,
  output logic [data_width_p-1:0]                  mem_data_o,
  output logic                                     mem_data_v_o,
  input  logic                                     mem_data_yumi_i
);
  localparam int pkt_w_lp = addr_width_p + 1;
  localparam int id_w_lp  = $clog2(num_caches_p);
  localparam int cnt_w_lp = (beats_per_block_p > 1) ? $clog2(beats_per_block_p) : 1;
  localparam int ptr_w_lp = (track_els_p > 1) ? $clog2(track_els_p) : 1;
  localparam int occ_w_lp = $clog2(track_els_p + 1);
  localparam logic [id_w_lp-1:0] last_id_lp = id_w_lp'(num_caches_p - 1);

  logic [pkt_w_lp-1:0]     pkt_li   [num_caches_p];
  logic [data_width_p-1:0] wdata_li [num_caches_p];
  logic [num_caches_p-1:0] eligible;
  // Index 0 tracks outstanding reads, index 1 outstanding writes.
  logic [1:0]              fifo_push, fifo_pop, fifo_full, fifo_empty, beat_xfer;
  logic [id_w_lp-1:0]      fifo_head [2];
  logic [id_w_lp-1:0]      grant_id;
  logic                    grant_found, grant_xfer;
  logic [id_w_lp-1:0]      rr_q, rr_d;

  for (genvar gi = 0; gi < num_caches_p; gi++) begin : g_port
    assign pkt_li[gi]   = dma_pkt_i[gi*pkt_w_lp +: pkt_w_lp];
    assign wdata_li[gi] = dma_data_i[gi*data_width_p +: data_width_p];
    assign dma_data_o[gi*data_width_p +: data_width_p] = mem_data_i;
    // Reset gates eligibility so the packet valid drops while reset is held.
    assign eligible[gi] = reset_n_i & dma_pkt_v_i[gi] & ~fifo_full[pkt_li[gi][pkt_w_lp-1]];
    assign dma_pkt_yumi_o[gi]  = grant_xfer & (grant_id == id_w_lp'(gi));
    assign dma_data_v_o[gi]    = mem_data_v_i & ~fifo_empty[0] & (fifo_head[0] == id_w_lp'(gi));
    assign dma_data_yumi_o[gi] = beat_xfer[1] & (fifo_head[1] == id_w_lp'(gi));
  end

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < num_caches_p; k++) begin
      idx = (int'(rr_q) + k) % num_caches_p;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = id_w_lp'(idx);
      end
    end
  end

  assign mem_pkt_v_o   = grant_found;
  assign mem_pkt_o     = pkt_li[grant_id];
  assign grant_xfer    = grant_found & mem_pkt_yumi_i;
  assign fifo_push[0]  = grant_xfer & ~mem_pkt_o[pkt_w_lp-1];
  assign fifo_push[1]  = grant_xfer &  mem_pkt_o[pkt_w_lp-1];

  always_comb begin
    rr_d = rr_q;
    if (grant_xfer) begin
      rr_d = (grant_id == last_id_lp) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign mem_data_ready_and_o = ~fifo_empty[0] & dma_data_ready_and_i[fifo_head[0]];
  assign mem_data_v_o         = ~fifo_empty[1] & dma_data_v_i[fifo_head[1]];
  assign mem_data_o           = wdata_li[fifo_head[1]];
  assign beat_xfer[0]         = mem_data_v_i & mem_data_ready_and_o;
  assign beat_xfer[1]         = mem_data_v_o & mem_data_yumi_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_order
    logic [id_w_lp-1:0]  slot_q [track_els_p];
    logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
    logic [occ_w_lp-1:0] occ_q, occ_d;
    logic [cnt_w_lp-1:0] beat_q, beat_d;
    logic                pop;

    assign fifo_full[gi]  = (occ_q == occ_w_lp'(track_els_p));
    assign fifo_empty[gi] = (occ_q == '0);
    assign fifo_head[gi]  = slot_q[head_q];
    assign fifo_pop[gi]   = pop;

    // The head entry retires on the last beat of its block.
    always_comb begin
      beat_d = beat_q;
      pop    = 1'b0;
      if (beat_xfer[gi]) begin
        if (beat_q == cnt_w_lp'(beats_per_block_p - 1)) begin
          beat_d = '0;
          pop    = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end

    always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (pop) begin
        head_d = (head_q == ptr_w_lp'(track_els_p - 1)) ? '0 : head_q + 1'b1;
      end
      if (fifo_push[gi]) begin
        tail_d = (tail_q == ptr_w_lp'(track_els_p - 1)) ? '0 : tail_q + 1'b1;
      end
      case ({fifo_push[gi], pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        head_q <= '0;
        tail_q <= '0;
        occ_q  <= '0;
        beat_q <= '0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        occ_q  <= occ_d;
        beat_q <= beat_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (fifo_push[gi]) begin
        slot_q[tail_q] <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_bp_me_cache_dma_arbiter.sv
// Scoreboard bench for bp_me_cache_dma_arbiter: expected packets and beat
// sources are queued as stimulus is issued and retired as the DUT hands off.
module tb_bp_me_cache_dma_arbiter;
  localparam int N   = 2;
  localparam int AW  = 28;
  localparam int DW  = 64;
  localparam int BPB = 8;
  localparam int TE  = 4;
  localparam int PW  = AW + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*PW-1:0] dma_pkt;
  logic [N-1:0]    dma_pkt_v, dma_pkt_yumi;
  logic [N*DW-1:0] dma_data_o;
  logic [N-1:0]    dma_data_v_o, dma_data_ready;
  logic [N*DW-1:0] dma_data_i;
  logic [N-1:0]    dma_data_v_i, dma_data_yumi;
  logic [PW-1:0]   mem_pkt;
  logic            mem_pkt_v, mem_pkt_yumi;
  logic [DW-1:0]   mem_data_i;
  logic            mem_data_v_i, mem_data_ready;
  logic [DW-1:0]   mem_data_o;
  logic            mem_data_v_o, mem_data_yumi;

  always #5 clk = ~clk;

  bp_me_cache_dma_arbiter #(
    .num_caches_p(N), .addr_width_p(AW), .data_width_p(DW),
    .beats_per_block_p(BPB), .track_els_p(TE)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dma_pkt_i(dma_pkt), .dma_pkt_v_i(dma_pkt_v), .dma_pkt_yumi_o(dma_pkt_yumi),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_and_i(dma_data_ready),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi),
    .mem_pkt_o(mem_pkt), .mem_pkt_v_o(mem_pkt_v), .mem_pkt_yumi_i(mem_pkt_yumi),
    .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i), .mem_data_ready_and_o(mem_data_ready),
    .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o), .mem_data_yumi_i(mem_data_yumi)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] exp_pkt_q [$];
  int            exp_id_q  [$];
  logic [DW-1:0] fill_src_q [$];
  logic [DW-1:0] wsrc_q [N][$];
  int            rd_out_q [$];
  int            wr_out_q [$];
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  task automatic drive_sources();
    mem_data_v_i = (fill_src_q.size() > 0);
    mem_data_i   = mem_data_v_i ? fill_src_q[0] : '0;
    for (int i = 0; i < N; i++) begin
      dma_data_v_i[i] = (wsrc_q[i].size() > 0);
      dma_data_i[i*DW +: DW] = dma_data_v_i[i] ? wsrc_q[i][0] : '0;
    end
  endtask

  task automatic set_pkt(input int c, input logic w, input logic [AW-1:0] a, input bit expect_it);
    dma_pkt[c*PW +: PW] = {w, a};
    dma_pkt_v[c] = 1'b1;
    if (expect_it) begin
      exp_pkt_q.push_back({w, a});
      exp_id_q.push_back(c);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives sources every cycle from negedge and checks every handshake
  // against the bench's own outstanding-order model.
  task automatic run(input string tag, input int max_cyc, input bit fixed, input bit toggle1,
                     output int cycles, output int n_fill, output logic [2:0] first_x);
    int gid, r, w;
    logic [2:0] x;
    logic [N-1:0] exp_v, exp_y;
    logic exp_rdy, exp_wv;
    cycles = 0; n_fill = 0; first_x = '0;
    while (cycles < max_cyc && (fixed || exp_pkt_q.size() > 0 || fill_src_q.size() > 0 ||
           wsrc_q[0].size() > 0 || wsrc_q[1].size() > 0)) begin
      if (toggle1) dma_data_ready[1] = ((cycles % 2) == 0);
      drive_sources();
      #1;
      x = '0; gid = -1;
      r = (rd_out_q.size() > 0) ? rd_out_q[0] : -1;
      w = (wr_out_q.size() > 0) ? wr_out_q[0] : -1;
      exp_rdy = (r >= 0) && dma_data_ready[r];
      exp_v   = (r >= 0 && mem_data_v_i) ? (N'(1) << r) : '0;
      exp_wv  = (w >= 0) && (wsrc_q[w].size() > 0);
      exp_y   = (exp_wv && mem_data_yumi) ? (N'(1) << w) : '0;
      n_cmp += 4;
      if (mem_data_ready !== exp_rdy) begin
        n_err++; $display("FAIL %s fill_ready cyc%0d: got %b want %b", tag, cycles, mem_data_ready, exp_rdy);
      end
      if (dma_data_v_o !== exp_v) begin
        n_err++; $display("FAIL %s fill_valid cyc%0d: got %b want %b", tag, cycles, dma_data_v_o, exp_v);
      end
      if (mem_data_v_o !== exp_wv) begin
        n_err++; $display("FAIL %s wr_valid cyc%0d: got %b want %b", tag, cycles, mem_data_v_o, exp_wv);
      end
      if (dma_data_yumi !== exp_y) begin
        n_err++; $display("FAIL %s wr_yumi cyc%0d: got %b want %b", tag, cycles, dma_data_yumi, exp_y);
      end
      if (mem_data_v_i && mem_data_ready && r >= 0) begin
        x[1] = 1'b1; n_fill++; n_cmp++;
        if (dma_data_o[r*DW +: DW] !== fill_src_q[0]) begin
          n_err++; $display("FAIL %s fill_data cyc%0d: got %h want %h", tag, cycles, dma_data_o[r*DW +: DW], fill_src_q[0]);
        end
        $display("%s: fill beat %h -> cache %0d", tag, fill_src_q[0], r);
        void'(fill_src_q.pop_front());
        if (rd_cnt == BPB - 1) begin rd_cnt = 0; void'(rd_out_q.pop_front()); end
        else rd_cnt++;
      end
      if (mem_data_v_o && mem_data_yumi && exp_wv) begin
        x[2] = 1'b1; n_cmp++;
        if (mem_data_o !== wsrc_q[w][0]) begin
          n_err++; $display("FAIL %s wr_data cyc%0d: got %h want %h", tag, cycles, mem_data_o, wsrc_q[w][0]);
        end
        $display("%s: write beat %h <- cache %0d", tag, wsrc_q[w][0], w);
        void'(wsrc_q[w].pop_front());
        if (wr_cnt == BPB - 1) begin wr_cnt = 0; void'(wr_out_q.pop_front()); end
        else wr_cnt++;
      end
      n_cmp++;
      if (mem_pkt_v && mem_pkt_yumi) begin
        x[0] = 1'b1;
        if (exp_pkt_q.size() == 0) begin
          n_err++; $display("FAIL %s unexpected_grant cyc%0d: got yumi %b pkt %h want none", tag, cycles, dma_pkt_yumi, mem_pkt);
        end else begin
          if (dma_pkt_yumi !== (N'(1) << exp_id_q[0]) || mem_pkt !== exp_pkt_q[0]) begin
            n_err++; $display("FAIL %s grant cyc%0d: got yumi %b pkt %h want yumi %b pkt %h", tag, cycles,
                              dma_pkt_yumi, mem_pkt, N'(1) << exp_id_q[0], exp_pkt_q[0]);
          end
          $display("%s: packet %h granted to cache %0d", tag, exp_pkt_q[0], exp_id_q[0]);
          gid = exp_id_q[0];
          if (exp_pkt_q[0][PW-1]) wr_out_q.push_back(gid);
          else rd_out_q.push_back(gid);
          void'(exp_pkt_q.pop_front());
          void'(exp_id_q.pop_front());
        end
      end else if (dma_pkt_yumi !== '0) begin
        n_err++; $display("FAIL %s stray_pkt_yumi cyc%0d: got %b want 0", tag, cycles, dma_pkt_yumi);
      end
      if (cycles == 0) first_x = x;
      tick();
      if (gid >= 0) dma_pkt_v[gid] = 1'b0;
      cycles++;
    end
    if (!fixed) begin
      n_cmp++;
      if (exp_pkt_q.size() > 0 || fill_src_q.size() > 0 || wsrc_q[0].size() > 0 || wsrc_q[1].size() > 0) begin
        n_err++; $display("FAIL %s timeout: got %0d pkts %0d fills pending want 0", tag, exp_pkt_q.size(), fill_src_q.size());
      end
    end
    drive_sources();
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if ({mem_pkt_v, mem_data_ready, mem_data_v_o, dma_pkt_yumi, dma_data_v_o, dma_data_yumi} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: got pkt_v %b rdy %b wv %b pyumi %b fv %b wyumi %b want all 0", tag,
               mem_pkt_v, mem_data_ready, mem_data_v_o, dma_pkt_yumi, dma_data_v_o, dma_data_yumi);
    end
    $display("%s: output check done", tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    dma_pkt = '0; dma_pkt_v = '1; dma_data_ready = '1;
    dma_data_i = '1; dma_data_v_i = '1;
    mem_pkt_yumi = 1'b1; mem_data_i = '1; mem_data_v_i = 1'b1; mem_data_yumi = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_zero_outputs("reset_async");
    tick(); tick();
    check_zero_outputs("reset_held");
    dma_pkt_v = '0; dma_data_v_i = '0; mem_data_v_i = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reads_rr();
    int c, nf; logic [2:0] fx;
    set_pkt(0, 1'b0, 28'h100, 1'b1);
    set_pkt(1, 1'b0, 28'h200, 1'b1);
    run("reads_rr_pkt", 10, 1'b0, 1'b0, c, nf, fx);
    for (int i = 0; i < BPB; i++) fill_src_q.push_back(64'hA5A5_0000_0000_00A0 + 64'(i));
    for (int i = 0; i < BPB; i++) fill_src_q.push_back(64'h5A5A_0000_0000_00B0 + 64'(i));
    run("reads_rr_fill", 40, 1'b0, 1'b0, c, nf, fx);
    n_cmp++;
    if (nf != 2 * BPB) begin n_err++; $display("FAIL reads_rr fill_count: got %0d want %0d", nf, 2 * BPB); end
    mem_data_v_i = 1'b1; mem_data_i = 64'hDEAD;
    #1;
    n_cmp++;
    if (mem_data_ready !== 1'b0 || dma_data_v_o !== '0) begin
      n_err++; $display("FAIL reads_rr empty_after: got rdy %b v %b want 0 0", mem_data_ready, dma_data_v_o);
    end
    tick();
    mem_data_v_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    int c, nf; logic [2:0] fx;
    for (int k = 0; k < TE; k++) begin
      set_pkt(0, 1'b0, 28'h300 + AW'(k * 'h40), 1'b1);
      run("full_issue", 10, 1'b0, 1'b0, c, nf, fx);
    end
    set_pkt(0, 1'b0, 28'h3FC0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (mem_pkt_v !== 1'b0) begin n_err++; $display("FAIL fifo_full blocked: got pkt_v %b want 0", mem_pkt_v); end
      tick();
    end
    mem_pkt_yumi = 1'b0;
    for (int i = 0; i < BPB; i++) fill_src_q.push_back(64'hC0 + 64'(i));
    run("full_fill", 20, 1'b0, 1'b0, c, nf, fx);
    #1;
    n_cmp++;
    if (mem_pkt_v !== 1'b1 || mem_pkt !== {1'b0, 28'h3FC0}) begin
      n_err++; $display("FAIL fifo_full unblocked: got v %b pkt %h want 1 %h", mem_pkt_v, mem_pkt, {1'b0, 28'h3FC0});
    end
    exp_pkt_q.push_back({1'b0, 28'h3FC0}); exp_id_q.push_back(0);
    mem_pkt_yumi = 1'b1;
    run("full_fifth", 10, 1'b0, 1'b0, c, nf, fx);
    for (int i = 0; i < TE * BPB; i++) fill_src_q.push_back(64'hC100 + 64'(i));
    run("full_drain", 80, 1'b0, 1'b0, c, nf, fx);
  endtask

  task automatic test_write_order();
    int c, nf; logic [2:0] fx;
    set_pkt(1, 1'b1, 28'h400, 1'b1);
    run("wr_order_pkt1", 10, 1'b0, 1'b0, c, nf, fx);
    set_pkt(0, 1'b1, 28'h500, 1'b1);
    run("wr_order_pkt0", 10, 1'b0, 1'b0, c, nf, fx);
    for (int i = 0; i < BPB; i++) wsrc_q[0].push_back(64'hD000 + 64'(i));
    run("wr_order_hold", 3, 1'b1, 1'b0, c, nf, fx);
    n_cmp++;
    if (wsrc_q[0].size() != BPB) begin
      n_err++; $display("FAIL wr_order early_consume: got %0d left want %0d", wsrc_q[0].size(), BPB);
    end
    for (int i = 0; i < BPB; i++) wsrc_q[1].push_back(64'hE000 + 64'(i));
    run("wr_order_data", 40, 1'b0, 1'b0, c, nf, fx);
  endtask

  task automatic test_backpressure();
    int c, nf; logic [2:0] fx;
    set_pkt(1, 1'b0, 28'h900, 1'b1);
    run("bp_pkt", 10, 1'b0, 1'b0, c, nf, fx);
    for (int i = 0; i < BPB; i++) fill_src_q.push_back(64'hF0 + 64'(i));
    run("backpressure", 40, 1'b0, 1'b1, c, nf, fx);
    n_cmp++;
    if (nf != BPB || c != 2 * BPB - 1) begin
      n_err++; $display("FAIL backpressure count: got %0d beats in %0d cycles want %0d in %0d", nf, c, BPB, 2 * BPB - 1);
    end
    dma_data_ready = '1;
  endtask

  task automatic test_concurrent();
    int c, nf; logic [2:0] fx;
    set_pkt(0, 1'b1, 28'h600, 1'b1);
    run("conc_wpkt", 10, 1'b0, 1'b0, c, nf, fx);
    set_pkt(1, 1'b0, 28'h700, 1'b1);
    run("conc_rpkt", 10, 1'b0, 1'b0, c, nf, fx);
    for (int i = 0; i < BPB; i++) wsrc_q[0].push_back(64'h6000 + 64'(i));
    for (int i = 0; i < BPB; i++) fill_src_q.push_back(64'h7000 + 64'(i));
    set_pkt(0, 1'b0, 28'h800, 1'b1);
    run("concurrent", 30, 1'b0, 1'b0, c, nf, fx);
    n_cmp++;
    if (fx !== 3'b111 || c != BPB) begin
      n_err++; $display("FAIL concurrent overlap: got first %b cycles %0d want 111 %0d", fx, c, BPB);
    end
  endtask

  task automatic test_reset_mid_burst();
    int c, nf; logic [2:0] fx;
    for (int i = 0; i < 3; i++) fill_src_q.push_back(64'h8000 + 64'(i));
    run("rst_burst", 10, 1'b0, 1'b0, c, nf, fx);
    mem_data_v_i = 1'b1; mem_data_i = 64'h8003;
    set_pkt(1, 1'b0, 28'h123, 1'b0);
    #1;
    n_cmp++;
    if (mem_data_ready !== 1'b1 || mem_pkt_v !== 1'b1) begin
      n_err++; $display("FAIL rst_mid before: got rdy %b pkt_v %b want 1 1", mem_data_ready, mem_pkt_v);
    end
    reset_n = 1'b0;
    #1 check_zero_outputs("rst_mid_async");
    tick();
    reset_n = 1'b1;
    dma_pkt_v = '0;
    rd_out_q.delete(); wr_out_q.delete(); rd_cnt = 0; wr_cnt = 0;
    dma_data_v_i[0] = 1'b1;
    #1;
    n_cmp++;
    if (mem_data_ready !== 1'b0 || dma_data_v_o !== '0 || mem_data_v_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid empty: got rdy %b fv %b wv %b want 0 0 0", mem_data_ready, dma_data_v_o, mem_data_v_o);
    end
    tick();
    set_pkt(0, 1'b0, 28'hA00, 1'b1);
    set_pkt(1, 1'b0, 28'hB00, 1'b1);
    run("rst_mid_rr", 10, 1'b0, 1'b0, c, nf, fx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_reads_rr();
    test_fifo_full();
    test_write_order();
    test_backpressure();
    test_concurrent();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_me_cache_dma_arbiter.md
Name: bp_me_cache_dma_arbiter

Overview:
- Shares one DRAM DMA channel among num_caches_p bsg_cache instances, e.g. multiple L2 slices behind a unicore or multicore tile.
- Round-robin arbitrates DMA packets.
- Steers returning read-fill beats to the cache that issued the read.
- Muxes eviction write-data beats from the cache that issued the write, in packet-grant order.
- Sits between the cache dma_* ports and the memory-side DMA link.

Parameters:
- num_caches_p, 2, number of requesting caches (≥2).
- addr_width_p, 28, DMA packet address width (caddr).
- data_width_p, 64, DMA data beat width (l2_fill_width).
- beats_per_block_p, 8, data beats per cache block (read fill or write evict).
- track_els_p, 4, depth of each outstanding-order FIFO (read and write).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- dma_pkt_i  in  num_caches_p*(addr_width_p+1)  per-cache DMA packet {write_not_read, addr}
- dma_pkt_v_i  in  num_caches_p  per-cache packet valid
- dma_pkt_yumi_o  out  num_caches_p  per-cache packet consumed
- dma_data_o  out  num_caches_p*data_width_p  per-cache read fill data (broadcast copy)
- dma_data_v_o  out  num_caches_p  per-cache fill valid
- dma_data_ready_and_i  in  num_caches_p  per-cache fill ready
- dma_data_i  in  num_caches_p*data_width_p  per-cache write data
- dma_data_v_i  in  num_caches_p  per-cache write data valid
- dma_data_yumi_o  out  num_caches_p  per-cache write data consumed
- mem_pkt_o  out  addr_width_p+1  arbitrated packet
- mem_pkt_v_o  out  1  packet valid
- mem_pkt_yumi_i  in  1  memory consumed packet
- mem_data_i  in  data_width_p  read fill data from memory
- mem_data_v_i  in  1  fill valid
- mem_data_ready_and_o  out  1  fill ready
- mem_data_o  out  data_width_p  write data to memory
- mem_data_v_o  out  1  write data valid
- mem_data_yumi_i  in  1  memory consumed write beat

Behaviour:
- Reset (async assert on reset_n_i low, sync deassert assumed upstream):
  - Both order FIFOs empty; both beat counters 0; RR pointer 0.
  - All valid/yumi/ready outputs 0.
- Eligibility: cache i is eligible iff dma_pkt_v_i[i] and the FIFO matching its write_not_read bit is not full.
  - Push-when-full is never allowed, even with a same-cycle pop.
- Arbitration:
  - Round-robin starting at the RR pointer, combinational.
  - mem_pkt_o is the selected packet; mem_pkt_v_o = any eligible.
  - dma_pkt_yumi_o[g] = mem_pkt_yumi_i for granted g only.
  - On yumi: push g into the read or write FIFO; RR pointer <= g+1 mod num_caches_p.
  - No yumi means no pointer change; the grant may change next cycle.
- Read return:
  - Head of read FIFO = r.
  - dma_data_v_o[r] = mem_data_v_i & read FIFO nonempty; other v=0.
  - mem_data_ready_and_o = nonempty & dma_data_ready_and_i[r].
  - dma_data_o carries mem_data_i to all caches.
  - Each handshake increments the read counter. At beats_per_block_p-1 the counter wraps to 0 and the FIFO pops.
- Write data:
  - Head of write FIFO = w.
  - mem_data_o = dma_data_i[w]; mem_data_v_o = nonempty & dma_data_v_i[w].
  - dma_data_yumi_o[w] = mem_data_yumi_i; other yumi=0.
  - Counter, wrap and pop follow the read rule.
  - Write beats from a cache not at the head are never consumed.
- Read and write paths are independent and may both transfer in the same cycle as a packet grant.
- Same-cycle push and pop on one FIFO is allowed when it is not full.
- Empty FIFO: mem_data_ready_and_o=0 and mem_data_v_o=0. Memory data arriving with nothing outstanding is never accepted.
- Mid-operation reset: all outstanding state is discarded immediately; outputs drop to 0 asynchronously.
- Packet width rule: the write_not_read bit is the MSB of each packet.

Test Plan:
- Reads round-robin: caches 0 and 1 both post reads (addr 0x100, 0x200) with yumi every cycle → grants 0 then 1. Eight fill beats 0xA0..0xA7 go to cache 0, then 0xB0..0xB7 to cache 1. Read FIFO is empty afterward.
- FIFO full: cache 0 issues 4 reads with memory holding fills → 5th read not eligible (mem_pkt_v_o=0). After 8 fill beats are accepted, the 5th is granted.
- Write ordering: cache 1 write granted, then cache 0 write; cache 0 asserts data first → no dma_data_yumi_o[0] until cache 1's 8 beats are consumed.
- Backpressure: cache 1 fill ready toggles 1/0 → mem_data_ready_and_o mirrors it. Exactly 8 handshakes occur, no beat is duplicated or dropped.
- Concurrent: write data streaming from cache 0 while read fill returns to cache 1 and a new packet from cache 0 is granted → all three complete in the same cycles.
- Reset mid-burst: reset_n_i low after 3 of 8 fill beats → all outputs 0 immediately. After release, the FIFOs are empty and the RR pointer is 0.
